jtpopeye_romarb: RTL

SDRAM read arbiter and single-word cache feeding the main CPU ROM port and the OBJ graphics ROM port of the Popeye core. It sits between the SDRAM controller and the game top level. It turns byte reads from the Z80 side and 32-bit word reads from the object renderer into single-word SDRAM burst requests. It also produces the `ready` signal that gates the main CPU reset after ROM download.

---
 rtl/jtpopeye_pkg.sv | 30 +++
 rtl/jtpopeye_romarb_cache.sv | 38 +++
 rtl/jtpopeye_romarb.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/jtpopeye_pkg.sv
// Shared definitions for the Popeye ROM arbiter: FSM encoding, client ids,
// default SDRAM offsets and the byte lane selector used by the main CPU port.
package jtpopeye_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ACK  = 2'd1,
        ST_WAIT_DATA = 2'd2
    } arb_state_t;

    localparam logic CLIENT_MAIN = 1'b0;
    localparam logic CLIENT_OBJ  = 1'b1;

    localparam logic [21:0] MAIN_OFFSET_DEF = 22'h000000;
    localparam logic [21:0] OBJ_OFFSET_DEF  = 22'h002000;

    localparam int TAG_W = 13;

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/jtpopeye_romarb_cache.sv
// Single-entry read cache: one 32-bit word with its tag and valid bit.
// A clear wins over a fill so download/loop reset always leaves it empty.
module jtpopeye_romarb_cache
    import jtpopeye_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             fill_en,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic [31:0]      fill_data,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             hit,
    output logic [31:0]      data
);

    logic             valid_q;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (clr) begin
            valid_q <= 1'b0;
        end else if (fill_en) begin
            valid_q <= 1'b1;
            tag_q   <= fill_tag;
            data_q  <= fill_data;
        end
    end

    assign hit  = valid_q && (tag_q == lookup_tag);
    assign data = data_q;

endmodule

// File: rtl/jtpopeye_romarb.sv
// SDRAM read arbiter for the main CPU ROM and OBJ ROM ports, with one cached
// word per client and the post-download ready delay.
module jtpopeye_romarb
    import jtpopeye_pkg::*;
#(
    parameter logic [21:0] MAIN_OFFSET = MAIN_OFFSET_DEF,
    parameter logic [21:0] OBJ_OFFSET  = OBJ_OFFSET_DEF,
    parameter int unsigned READY_DLY   = 16
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic        loop_rst,
    input  logic        main_cs,
    input  logic [14:0] main_addr,
    output logic [7:0]  main_dout,
    output logic        main_ok,
    input  logic [12:0] obj_addr,
    output logic [31:0] obj_dout,
    output logic        obj_ok,
    output logic        ready,
    output logic        sdram_req,
    input  logic        sdram_ack,
    input  logic        data_rdy,
    output logic [21:0] sdram_addr,
    input  logic [31:0] data_read,
    output logic        refresh_en
);

    arb_state_t       state_q, state_d;
    logic             client_q, client_d;
    logic             last_q, last_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [21:0]      addr_q, addr_d;
    logic             req_q, req_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             ready_q, ready_d;

    logic             hold;
    logic             fill;
    logic             pick_obj;
    logic [TAG_W-1:0] main_tag;
    logic [TAG_W-1:0] pick_tag;
    logic             main_hit, obj_hit;
    logic             main_miss, obj_miss;
    logic [31:0]      main_word, obj_word;

    assign hold      = downloading | loop_rst;
    assign main_tag  = main_addr[14:2];
    assign main_miss = main_cs & ~main_hit;
    assign obj_miss  = ~obj_hit;

    jtpopeye_romarb_cache u_main_cache (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (hold),
        .fill_en    (fill && client_q == CLIENT_MAIN),
        .fill_tag   (tag_q),
        .fill_data  (data_read),
        .lookup_tag (main_tag),
        .hit        (main_hit),
        .data       (main_word)
    );

    jtpopeye_romarb_cache u_obj_cache (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (hold),
        .fill_en    (fill && client_q == CLIENT_OBJ),
        .fill_tag   (tag_q),
        .fill_data  (data_read),
        .lookup_tag (obj_addr),
        .hit        (obj_hit),
        .data       (obj_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            client_q <= CLIENT_MAIN;
            last_q   <= CLIENT_OBJ;
            tag_q    <= '0;
            addr_q   <= '0;
            req_q    <= 1'b0;
            cnt_q    <= 16'(READY_DLY);
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            client_q <= client_d;
            last_q   <= last_d;
            tag_q    <= tag_d;
            addr_q   <= addr_d;
            req_q    <= req_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
        end
    end

    // On a double miss, the client that was not served last goes first.
    assign pick_obj = obj_miss & (~main_miss | (last_q == CLIENT_MAIN));
    assign pick_tag = pick_obj ? obj_addr : main_tag;

    always_comb begin
        state_d  = state_q;
        client_d = client_q;
        last_d   = last_q;
        tag_d    = tag_q;
        addr_d   = addr_q;
        req_d    = req_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        fill     = 1'b0;

        if (hold) begin
            cnt_d   = 16'(READY_DLY);
            ready_d = 1'b0;
        end else begin
            if (cnt_q != 16'd0) begin
                cnt_d = cnt_q - 16'd1;
            end
            ready_d = (cnt_q == 16'd0);
        end

        if (hold) begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ready_q && (main_miss || obj_miss)) begin
                        client_d = pick_obj ? CLIENT_OBJ : CLIENT_MAIN;
                        tag_d    = pick_tag;
                        addr_d   = (pick_obj ? OBJ_OFFSET : MAIN_OFFSET) + {9'd0, pick_tag};
                        req_d    = 1'b1;
                        state_d  = ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (sdram_ack) begin
                        req_d = 1'b0;
                        if (data_rdy) begin
                            fill    = 1'b1;
                            last_d  = client_q;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_WAIT_DATA;
                        end
                    end
                end
                ST_WAIT_DATA: begin
                    if (data_rdy) begin
                        fill    = 1'b1;
                        last_d  = client_q;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    assign main_ok    = main_hit & main_cs;
    assign obj_ok     = obj_hit;
    assign main_dout  = byte_sel(main_word, main_addr[1:0]);
    assign obj_dout   = obj_word;
    assign ready      = ready_q;
    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;
    assign refresh_en = (state_q == ST_IDLE) && !(main_miss || obj_miss);

endmodule
